// File: rtl/pwm_multi_channel_driver.sv
// Multi-channel PWM: one shared period counter feeding CHANNELS duty comparators.
// Define PWM_SHADOW_EN to double-buffer level/period writes until the next wrap.

module pwm_channel #(
    parameter int RES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           wr,
`ifdef PWM_SHADOW_EN
    input  logic           commit,
`endif
    input  logic [RES-1:0] level,
    input  logic [RES-1:0] counter,
    output logic           pwm
);

    logic [RES-1:0] active;

`ifdef PWM_SHADOW_EN
    logic [RES-1:0] shadow;
    logic [RES-1:0] shadow_nxt;

    // A write landing on the wrap edge must be committed on that same edge.
    assign shadow_nxt = wr ? level : shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (commit)
                active <= shadow_nxt;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            active <= '0;
        else if (wr)
            active <= level;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            pwm <= 1'b0;
        else
            pwm <= en && (counter < active);
    end

endmodule

module pwm_multi_channel_driver #(
    parameter int CHANNELS = 8,
    parameter int RES      = 3,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pset,
    input  logic                pper,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [RES-1:0]      level,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                wrap
);

    localparam logic [RES-1:0] PERIOD_RST = RES'((1 << RES) - 2);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("CHANNELS must be in 1..16");
    end
    if (RES < 2 || RES > 8) begin : g_bad_res
        $error("RES must be in 2..8");
    end
    if ((1 << ADDR_W) < CHANNELS) begin : g_bad_addr
        $error("ADDR_W too narrow for CHANNELS");
    end

    logic [RES-1:0]      counter;
    logic [RES-1:0]      period_reg;
    logic                wrap_evt;
    logic [CHANNELS-1:0] sel;

    // >= rather than == so a period shrunk below the current count wraps at once.
    assign wrap_evt = en && (counter >= period_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= wrap_evt;
            if (en)
                counter <= wrap_evt ? '0 : counter + RES'(1);
        end
    end

`ifdef PWM_SHADOW_EN
    logic [RES-1:0] shadow_period;
    logic [RES-1:0] shadow_period_nxt;

    assign shadow_period_nxt = pper ? level : shadow_period;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_period <= PERIOD_RST;
            period_reg    <= PERIOD_RST;
        end else begin
            shadow_period <= shadow_period_nxt;
            if (wrap_evt)
                period_reg <= shadow_period_nxt;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            period_reg <= PERIOD_RST;
        else if (pper)
            period_reg <= level;
    end
`endif

    // Only addresses below CHANNELS decode, so out-of-range writes fall away.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign sel[i] = pset && (addr == ADDR_W'(i));

        pwm_channel #(.RES(RES)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wr      (sel[i]),
`ifdef PWM_SHADOW_EN
            .commit  (wrap_evt),
`endif
            .level   (level),
            .counter (counter),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel_driver.sv
// Randomised bench for pwm_multi_channel_driver against a behavioural PWM model,
// plus directed scenarios with hand-computed expectations.

module tb_pwm_multi_channel_driver;

    localparam int CH  = 8;
    localparam int RES = 3;
    localparam int AW  = 4;   // wider than needed so out-of-range addresses exist

    logic          clk = 1'b0;
    logic          rst, en, pset, pper;
    logic [AW-1:0] addr;
    logic [RES-1:0] level;
    logic [CH-1:0] pwm_out;
    logic          wrap;

    always #5 clk = ~clk;

    pwm_multi_channel_driver #(.CHANNELS(CH), .RES(RES), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .pset    (pset),
        .pper    (pper),
        .addr    (addr),
        .level   (level),
        .pwm_out (pwm_out),
        .wrap    (wrap)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: plain integers for count, period and duty per channel.
    int m_cnt = 0;
    int m_per = 6;
    int m_act[CH];
    int m_sh[CH];
    int m_shper = 6;
    logic [CH-1:0] m_pwm = '0;
    logic          m_wrap = 1'b0;

    task automatic model_edge();
        bit w;
        if (rst) begin
            m_cnt = 0; m_per = 6; m_shper = 6;
            for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_sh[i] = 0; end
            m_pwm = '0; m_wrap = 1'b0;
        end else begin
            w = en && (m_cnt >= m_per);
            for (int i = 0; i < CH; i++) m_pwm[i] = en && (m_cnt < m_act[i]);
            m_wrap = w;
            if (en) m_cnt = w ? 0 : m_cnt + 1;
`ifdef PWM_SHADOW_EN
            if (pset && int'(addr) < CH) m_sh[addr] = int'(level);
            if (pper) m_shper = int'(level);
            if (w) begin
                for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
                m_per = m_shper;
            end
`else
            if (pset && int'(addr) < CH) m_act[addr] = int'(level);
            if (pper) m_per = int'(level);
`endif
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare just after.
    task automatic cyc(input bit r, input bit e, input bit ps, input bit pp,
                       input int a, input int l);
        @(negedge clk);
        rst = r; en = e; pset = ps; pper = pp; addr = AW'(a); level = RES'(l);
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
        if (pwm_out !== m_pwm || wrap !== m_wrap) begin
            miscompares++;
            $display("FAIL model t=%0t pwm_out=%b wrap=%b expected pwm_out=%b wrap=%b",
                     $time, pwm_out, wrap, m_pwm, m_wrap);
        end
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_wrap(input string name);
        bit found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            idle();
            if (wrap === 1'b1) found = 1;
        end
        lit(name, int'(found), 1);
    endtask

    initial begin
        int first_wrap, n_wrap;
        int hi[CH];
        rst = 1; en = 0; pset = 0; pper = 0; addr = '0; level = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        lit("reset_pwm", int'(pwm_out), 0);
        lit("reset_wrap", int'(wrap), 0);

        // Default period: 7-cycle wraps, outputs low
        first_wrap = -1; n_wrap = 0;
        for (int c = 1; c <= 21; c++) begin
            idle();
            if (wrap === 1'b1) begin
                n_wrap++;
                if (first_wrap < 0) first_wrap = c;
            end
            lit("default_pwm_low", int'(pwm_out), 0);
        end
        lit("first_wrap_edge", first_wrap, 7);
        lit("wrap_count_21", n_wrap, 3);

        // Duty levels ch0=1, ch3=4, ch7=7
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 1, 1, 0, 3, 4);
        cyc(0, 1, 1, 0, 7, 7);
        wait_wrap("wrap_after_levels");
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int c = 0; c < 7; c++) begin
            idle();
            for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
        end
        lit("duty_ch0", hi[0], 1);
        lit("duty_ch3", hi[3], 4);
        lit("duty_ch7", hi[7], 7);
        lit("duty_ch1", hi[1], 0);

        // Last loop ended on a wrap edge (counter=0); walk to counter=5, then pper=3
        for (int c = 0; c < 5; c++) idle();
        cyc(0, 1, 0, 1, 0, 3);
        idle();
        lit("period_shrink_wrap", int'(wrap), 1);
        n_wrap = 0; hi[3] = 0;
        for (int c = 0; c < 8; c++) begin
            idle();
            n_wrap += int'(wrap);
            hi[3] += int'(pwm_out[3]);
        end
        lit("period4_wraps", n_wrap, 2);
        lit("ch3_const_high", hi[3], 8);

        // Enable low: outputs forced low, counter frozen
        for (int c = 0; c < 10; c++) begin
            cyc(0, 0, 0, 0, 0, 0);
            lit("en0_pwm", int'(pwm_out), 0);
            lit("en0_wrap", int'(wrap), 0);
        end
        for (int c = 0; c < 6; c++) idle();

        // Out-of-range address must not alias onto ch1
        cyc(0, 1, 1, 0, 9, 7);
        cyc(0, 1, 1, 0, 15, 7);
        hi[1] = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            hi[1] += int'(pwm_out[1]);
        end
        lit("bad_addr_ch1", hi[1], 0);

        // Mid-run reset discards all programming
        cyc(0, 1, 1, 0, 2, 5);
        cyc(0, 1, 0, 1, 0, 6);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        lit("midreset_pwm", int'(pwm_out), 0);
        for (int c = 0; c < 14; c++) begin
            idle();
            lit("post_reset_low", int'(pwm_out), 0);
        end

        // Random traffic checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom_range(199) == 0),
                ($urandom_range(9) != 0),
                ($urandom_range(9) < 3),
                ($urandom_range(19) == 0),
                int'($urandom_range(15)),
                int'($urandom_range(7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
